// File: rtl/char_stream_tokenizer_pkg.sv
// Shared types and constants for the char-stream tokenizer: token kinds,
// lexer/top FSM states and the ASCII delimiters the lexer reacts to.
package char_stream_tokenizer_pkg;

    localparam int CHAR_BITES = 8;
    localparam int TOK_KIND_W = 3;
    localparam int TOK_W      = TOK_KIND_W + CHAR_BITES;

    typedef enum logic [TOK_KIND_W-1:0] {
        TOK_TEXT       = 3'd0,
        TOK_OPEN_NAME  = 3'd1,
        TOK_CLOSE_NAME = 3'd2,
        TOK_TAG_END    = 3'd3,
        TOK_STREAM_END = 3'd4
    } tok_kind_e;

    typedef enum logic [2:0] {
        LEX_TEXT,
        LEX_TAG_OPEN,
        LEX_TAG_NAME,
        LEX_CLOSE_NAME,
        LEX_TAG_ATTR
    } lex_state_e;

    typedef enum logic [1:0] {
        TOP_IDLE,
        TOP_RUN,
        TOP_DRAIN
    } top_state_e;

    localparam logic [CHAR_BITES-1:0] CH_LT    = 8'h3C;
    localparam logic [CHAR_BITES-1:0] CH_GT    = 8'h3E;
    localparam logic [CHAR_BITES-1:0] CH_SLASH = 8'h2F;
    localparam logic [CHAR_BITES-1:0] CH_SPACE = 8'h20;
    localparam logic [CHAR_BITES-1:0] CH_TAB   = 8'h09;
    localparam logic [CHAR_BITES-1:0] CH_LF    = 8'h0A;

endpackage

// File: rtl/char_stream_tokenizer_fifo.sv
// First-word-fall-through token FIFO with occupancy count; head reads as 0
// while empty so the token outputs are clean out of reset.
module tok_fifo
    import char_stream_tokenizer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = TOK_W
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign rd_valid = (count != '0);
    assign do_pop   = pop & rd_valid;
    assign do_push  = push & ((count != FULL_LVL) | do_pop);
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/char_stream_tokenizer.sv
// Drives a char reader, lexes its stream into HTML tokens and queues them.
// Define TOKENIZER_LOWERCASE_EN to fold A-Z in tag names to lowercase.
module char_stream_tokenizer
    import char_stream_tokenizer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [7:0]            source_sel,
    output logic                  busy,
    output logic                  done,
    output logic                  state_enable,
    output logic [7:0]            argument,
    output logic                  pause,
    input  logic                  has_finished,
    input  logic [CHAR_BITES-1:0] char,
    output logic                  tok_valid,
    input  logic                  tok_ready,
    output logic [TOK_KIND_W-1:0] tok_kind,
    output logic [CHAR_BITES-1:0] tok_char
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] PAUSE_LVL = CW'(DEPTH - 2);

    top_state_e            top_q;
    lex_state_e            lex_q;
    lex_state_e            lex_next;
    logic                  issued_q;
    logic                  cap_vld_p0;
    logic                  end_det_p0;
    logic                  lex_push;
    tok_kind_e             lex_kind;
    logic [CHAR_BITES-1:0] lex_char;
    logic                  push_vld_p0;
    tok_kind_e             push_kind_p0;
    logic [CHAR_BITES-1:0] push_char_p0;
    logic                  pop;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic [TOK_W-1:0]      fifo_head;

    function automatic logic [CHAR_BITES-1:0] fold_name(input logic [CHAR_BITES-1:0] c);
`ifdef TOKENIZER_LOWERCASE_EN
        return (c >= 8'h41 && c <= 8'h5A) ? c + 8'd32 : c;
`else
        return c;
`endif
    endfunction

    function automatic logic is_space(input logic [CHAR_BITES-1:0] c);
        return (c == CH_SPACE) || (c == CH_TAB) || (c == CH_LF);
    endfunction

    // Capture stage: reader char lands one edge after an issue
    assign cap_vld_p0 = issued_q & ~has_finished & (top_q == TOP_RUN);
    assign end_det_p0 = (top_q == TOP_RUN) & (has_finished | (cap_vld_p0 & (char == '0)));

    always_comb begin
        lex_push = 1'b0;
        lex_kind = TOK_TEXT;
        lex_char = char;
        lex_next = lex_q;
        case (lex_q)
            LEX_TEXT: begin
                if (char == CH_LT) lex_next = LEX_TAG_OPEN;
                else               lex_push = 1'b1;
            end
            LEX_TAG_OPEN: begin
                if (char == CH_SLASH)   lex_next = LEX_CLOSE_NAME;
                else if (char == CH_GT) lex_next = LEX_TEXT;
                else if (char != CH_LT) begin
                    lex_push = 1'b1;
                    lex_kind = TOK_OPEN_NAME;
                    lex_char = fold_name(char);
                    lex_next = LEX_TAG_NAME;
                end
            end
            LEX_TAG_NAME, LEX_CLOSE_NAME: begin
                if (char == CH_GT) begin
                    lex_push = 1'b1;
                    lex_kind = TOK_TAG_END;
                    lex_char = '0;
                    lex_next = LEX_TEXT;
                end else if (is_space(char)) begin
                    lex_next = LEX_TAG_ATTR;
                end else if (char != CH_LT) begin
                    lex_push = 1'b1;
                    lex_kind = (lex_q == LEX_TAG_NAME) ? TOK_OPEN_NAME : TOK_CLOSE_NAME;
                    lex_char = fold_name(char);
                end
            end
            LEX_TAG_ATTR: begin
                if (char == CH_GT) begin
                    lex_push = 1'b1;
                    lex_kind = TOK_TAG_END;
                    lex_char = '0;
                    lex_next = LEX_TEXT;
                end
            end
            default: lex_next = LEX_TEXT;
        endcase
    end

    // Push stage: STREAM_END takes priority over any lexer token
    assign push_vld_p0  = end_det_p0 | (cap_vld_p0 & lex_push);
    assign push_kind_p0 = end_det_p0 ? TOK_STREAM_END : lex_kind;
    assign push_char_p0 = end_det_p0 ? '0 : lex_char;
    assign pop          = tok_valid & tok_ready;
    assign count_next   = count + CW'(push_vld_p0) - CW'(pop);

    tok_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TOK_W)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (push_vld_p0),
        .wr_data  ({push_kind_p0, push_char_p0}),
        .pop      (pop),
        .rd_data  (fifo_head),
        .rd_valid (tok_valid),
        .count    (count)
    );

    assign {tok_kind, tok_char} = fifo_head;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            top_q        <= TOP_IDLE;
            lex_q        <= LEX_TEXT;
            issued_q     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            state_enable <= 1'b0;
            pause        <= 1'b0;
            argument     <= '0;
        end else begin
            issued_q <= state_enable & ~pause & ~has_finished;
            pause    <= (count_next >= PAUSE_LVL);
            done     <= 1'b0;
            case (top_q)
                TOP_IDLE: begin
                    if (start) begin
                        top_q        <= TOP_RUN;
                        busy         <= 1'b1;
                        state_enable <= 1'b1;
                        argument     <= source_sel;
                        lex_q        <= LEX_TEXT;
                    end
                end
                TOP_RUN: begin
                    if (end_det_p0) begin
                        top_q        <= TOP_DRAIN;
                        state_enable <= 1'b0;
                    end else if (cap_vld_p0) begin
                        lex_q <= lex_next;
                    end
                end
                TOP_DRAIN: begin
                    if (count == '0) begin
                        top_q <= TOP_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: top_q <= TOP_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_char_stream_tokenizer.sv
// Bench for char_stream_tokenizer: stub reader, random ready throttling and a
// string-level tokenizer reference that predicts the token sequence.
module tb_char_stream_tokenizer;
    import char_stream_tokenizer_pkg::*;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] source_sel = 8'h00;
    logic       busy, done, state_enable, pause;
    logic [7:0] argument;
    logic       has_finished = 1'b0;
    logic [7:0] char = 8'h00;
    logic       tok_valid;
    logic       tok_ready = 1'b0;
    logic [2:0] tok_kind;
    logic [7:0] tok_char;

    always #5 clock = ~clock;

    char_stream_tokenizer #(.DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .source_sel   (source_sel),
        .busy         (busy),
        .done         (done),
        .state_enable (state_enable),
        .argument     (argument),
        .pause        (pause),
        .has_finished (has_finished),
        .char         (char),
        .tok_valid    (tok_valid),
        .tok_ready    (tok_ready),
        .tok_kind     (tok_kind),
        .tok_char     (tok_char)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Stub reader: one char per unpaused enabled edge, then has_finished.
    byte unsigned stim[$];
    int rd_idx = 0;
    always @(posedge clock) begin
        if (!state_enable) begin
            rd_idx       <= 0;
            has_finished <= 1'b0;
        end else if (!pause && !has_finished) begin
            if (rd_idx < stim.size()) begin
                char   <= stim[rd_idx];
                rd_idx <= rd_idx + 1;
            end else begin
                has_finished <= 1'b1;
            end
        end
    end

    function automatic byte unsigned tb_fold(input byte unsigned c);
`ifdef TOKENIZER_LOWERCASE_EN
        if (c >= 8'h41 && c <= 8'h5A) return c + 8'd32;
`endif
        return c;
    endfunction

    function automatic bit is_ws(input byte unsigned c);
        return (c == 8'h20) || (c == 8'h09) || (c == 8'h0A);
    endfunction

    logic [10:0] exp_q[$];

    // Reference: split the stream into text runs and <...> segments.
    function automatic void build_expected();
        int n = stim.size();
        int i = 0;
        byte unsigned seg[$];
        bit closed;
        logic [2:0] kind;
        exp_q.delete();
        while (i < n && stim[i] != 0) begin
            if (stim[i] != 8'h3C) begin
                exp_q.push_back({TOK_TEXT, stim[i]});
                i++;
            end else begin
                seg.delete();
                closed = 1'b0;
                i++;
                while (i < n && stim[i] != 0 && stim[i] != 8'h3E) begin
                    if (stim[i] != 8'h3C) seg.push_back(stim[i]);
                    i++;
                end
                if (i < n && stim[i] == 8'h3E) begin
                    closed = 1'b1;
                    i++;
                end
                if (seg.size() > 0) begin
                    if (seg[0] == 8'h2F) begin
                        kind = TOK_CLOSE_NAME;
                    end else begin
                        kind = TOK_OPEN_NAME;
                        exp_q.push_back({kind, tb_fold(seg[0])});
                    end
                    for (int k = 1; k < seg.size() && !is_ws(seg[k]); k++)
                        exp_q.push_back({kind, tb_fold(seg[k])});
                    if (closed) exp_q.push_back({TOK_TAG_END, 8'h00});
                end
            end
        end
        exp_q.push_back({TOK_STREAM_END, 8'h00});
    endfunction

    task automatic set_stim(input string s);
        stim.delete();
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
    endtask

    // Token monitor: drives ready away from the edge, checks pops and holds.
    int   ready_mode = 0;
    bit   mon_en = 1'b0;
    int   cyc_cnt = 0;
    int   last_pop_cyc = 0;
    int   done_cyc = 0;
    logic prev_stall = 1'b0;
    logic [10:0] prev_tok = '0;

    always @(negedge clock) begin
        cyc_cnt++;
        case (ready_mode)
            0:       tok_ready = 1'b1;
            1:       tok_ready = 1'($urandom_range(0, 1));
            default: tok_ready = 1'b0;
        endcase
        if (mon_en) begin
            if (prev_stall)
                check_val("hold", 32'({tok_valid, tok_kind, tok_char}), 32'({1'b1, prev_tok}));
            if (done) done_cyc = cyc_cnt;
            if (tok_valid && tok_ready) begin
                if (exp_q.size() == 0)
                    check_val("extra_tok", 32'({tok_kind, tok_char}), 32'h7FF);
                else
                    check_val("tok", 32'({tok_kind, tok_char}), 32'(exp_q.pop_front()));
                last_pop_cyc = cyc_cnt;
            end
            prev_stall = tok_valid & ~tok_ready;
            prev_tok   = {tok_kind, tok_char};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic start_stream(input int rmode, input logic [7:0] sel);
        build_expected();
        ready_mode = rmode;
        mon_en = 1'b1;
        @(negedge clock);
        start = 1'b1;
        source_sel = sel;
        @(negedge clock);
        start = 1'b0;
        check_val("busy_on", 32'(busy), 32'd1);
        check_val("argument", 32'(argument), 32'(sel));
    endtask

    task automatic finish_stream(input bit chk_lat);
        int lat = -1;
        for (int c = 0; c < 3000 && done !== 1'b1; c++) begin
            if (lat < 0 && tok_valid === 1'b1) lat = c;
            @(negedge clock);
        end
        check_val("done_seen", 32'(done), 32'd1);
        if (chk_lat) check_val("first_tok_lat", 32'(lat), 32'd2);
        @(negedge clock);
        check_val("done_pulse", 32'(done), 32'd0);
        check_val("busy_off", 32'(busy), 32'd0);
        check_val("enable_off", 32'(state_enable), 32'd0);
        check_val("done_after_pop", 32'(done_cyc - last_pop_cyc), 32'd2);
        check_val("tokens_left", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
    endtask

    task automatic run_stream(input int rmode, input logic [7:0] sel);
        start_stream(rmode, sel);
        finish_stream(stim[0] != 8'h3C);
    endtask

    task automatic check_all_zero(input string pfx);
        check_val({pfx, "_busy"}, 32'(busy), 32'd0);
        check_val({pfx, "_done"}, 32'(done), 32'd0);
        check_val({pfx, "_enable"}, 32'(state_enable), 32'd0);
        check_val({pfx, "_pause"}, 32'(pause), 32'd0);
        check_val({pfx, "_valid"}, 32'(tok_valid), 32'd0);
        check_val({pfx, "_arg"}, 32'(argument), 32'd0);
        check_val({pfx, "_tok"}, 32'({tok_kind, tok_char}), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    byte unsigned alpha [16] = '{8'h61, 8'h62, 8'h5A, 8'h51, 8'h3C, 8'h3E, 8'h2F, 8'h20,
                                 8'h09, 8'h0A, 8'h3D, 8'h78, 8'h3C, 8'h3E, 8'h44, 8'h2F};

    initial begin
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        set_stim("test");          run_stream(0, 8'h11);
        set_stim("<p>hi</p>");     run_stream(0, 8'h22);
        set_stim("<a href=x>");    run_stream(0, 8'h33);
        set_stim("<>");            run_stream(0, 8'h44);
        set_stim("<DIV>");         run_stream(0, 8'h55);
        set_stim("</B c>x< /y>");  run_stream(1, 8'h56);
        set_stim("ab");
        stim.push_back(8'h00);
        stim.push_back(8'h63);
        stim.push_back(8'h64);
        run_stream(0, 8'h66);

        // Throttled run with an ignored start while busy
        set_stim("<p>hi</p>");
        start_stream(2, 8'h77);
        repeat (20) @(negedge clock);
        check_val("pause_full", 32'(pause), 32'd1);
        check_val("valid_stalled", 32'(tok_valid), 32'd1);
        check_val("done_stalled", 32'(done), 32'd0);
        start = 1'b1;
        source_sel = 8'h99;
        @(negedge clock);
        start = 1'b0;
        check_val("arg_kept", 32'(argument), 32'h77);
        check_val("busy_kept", 32'(busy), 32'd1);
        ready_mode = 0;
        finish_stream(1'b0);

        // Reset mid-stream, then a clean rerun of the same stream
        set_stim("ab<em>cd</em>ef");
        start_stream(1, 8'h5A);
        repeat (6) @(negedge clock);
        mon_en = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_all_zero("midreset");
        exp_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        run_stream(0, 8'h5B);

        for (int t = 0; t < 25; t++) begin
            int len;
            stim.delete();
            len = $urandom_range(1, 16);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 29) == 0) stim.push_back(8'h00);
                else stim.push_back(alpha[$urandom_range(0, 15)]);
            end
            run_stream((t % 3 == 0) ? 0 : 1, 8'($urandom_range(0, 255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
